// File: rtl/pbs_turn_ctrl.sv
// Turn scheduler for the battle simulator: owns both HP counters and time-shares
// one damage/heal datapath between the player and AI actions of each turn.
module pbs_turn_ctrl #(
   parameter int unsigned HP_MAX = 100,
   parameter int unsigned HEAL   = 20
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       go,
   input  logic [7:0] player_hp_init,
   input  logic [7:0] ai_hp_init,
   input  logic [1:0] player_move,
   input  logic [1:0] ai_move,
   input  logic [3:0] player_atk,
   input  logic [3:0] ai_atk,
   output logic [7:0] player_hp,
   output logic [7:0] ai_hp,
   output logic [7:0] turn_count,
   output logic       busy,
   output logic       victory,
   output logic       loss,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_IDLE_WAIT = 4'd1,
      S_MOVE      = 4'd2,
      S_MOVE_WAIT = 4'd3,
      S_P_CALC    = 4'd4,
      S_P_APPLY   = 4'd5,
      S_P_CHECK   = 4'd6,
      S_A_CALC    = 4'd7,
      S_A_APPLY   = 4'd8,
      S_A_CHECK   = 4'd9,
      S_WIN       = 4'd10,
      S_LOSE      = 4'd11
   } state_t;

   localparam logic [7:0] HP_MAX_B = 8'(HP_MAX);
   localparam logic [7:0] HEAL_B   = 8'(HEAL);
   localparam logic [1:0] MV_HEAL  = 2'd3;

   state_t     state_q, nxt;
   logic [7:0] player_hp_q, ai_hp_q, turn_q, dmg_q;
   logic [1:0] pmove_q, amove_q;
   logic       end_q;
   logic       busy_q, victory_q, loss_q;

   function automatic logic [7:0] load_hp(input logic [7:0] init);
      if (init == 8'd0)        return 8'd1;
      else if (init > HP_MAX_B) return HP_MAX_B;
      else                     return init;
   endfunction

   // Move power is 4, 8, 12 for moves 0..2; product fits 8 bits (max 180).
   function automatic logic [7:0] calc_dmg(input logic [1:0] mv, input logic [3:0] atk);
      logic [3:0] power;
      power = 4'(({2'b00, mv} + 4'd1) << 2);
      if (mv == MV_HEAL) return HEAL_B;
      else               return power * atk;
   endfunction

   function automatic logic [7:0] hit(input logic [7:0] hp, input logic [7:0] dmg);
      return (hp <= dmg) ? 8'd0 : hp - dmg;
   endfunction

   function automatic logic [7:0] heal(input logic [7:0] hp);
      logic [8:0] sum;
      sum = {1'b0, hp} + {1'b0, HEAL_B};
      return (sum > {1'b0, HP_MAX_B}) ? HP_MAX_B : sum[7:0];
   endfunction

   // NOTE: every variable in an always_comb gets a default first so no latch is inferred.
   always_comb begin
      nxt = state_q;
      case (state_q)
         S_IDLE:      if (go)  nxt = S_IDLE_WAIT;
         S_IDLE_WAIT: if (!go) nxt = end_q ? S_IDLE : S_MOVE;
         S_MOVE:      if (go)  nxt = S_MOVE_WAIT;
         S_MOVE_WAIT: if (!go) nxt = S_P_CALC;
         S_P_CALC:    nxt = S_P_APPLY;
         S_P_APPLY:   nxt = S_P_CHECK;
         S_P_CHECK:   nxt = (ai_hp_q == 8'd0) ? S_WIN : S_A_CALC;
         S_A_CALC:    nxt = S_A_APPLY;
         S_A_APPLY:   nxt = S_A_CHECK;
         S_A_CHECK:   nxt = (player_hp_q == 8'd0) ? S_LOSE : S_MOVE;
         S_WIN,
         S_LOSE:      if (go)  nxt = S_IDLE_WAIT;
         default:     nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         player_hp_q <= 8'd0;
         ai_hp_q     <= 8'd0;
         turn_q      <= 8'd0;
         dmg_q       <= 8'd0;
         pmove_q     <= 2'd0;
         amove_q     <= 2'd0;
         end_q       <= 1'b0;
         busy_q      <= 1'b0;
         victory_q   <= 1'b0;
         loss_q      <= 1'b0;
      end else begin
         state_q   <= nxt;
         busy_q    <= nxt inside {S_P_CALC, S_P_APPLY, S_P_CHECK,
                                  S_A_CALC, S_A_APPLY, S_A_CHECK};
         victory_q <= (nxt == S_WIN);
         loss_q    <= (nxt == S_LOSE);

         case (state_q)
            S_IDLE: begin
               end_q <= 1'b0;
               if (go) begin
                  player_hp_q <= load_hp(player_hp_init);
                  ai_hp_q     <= load_hp(ai_hp_init);
                  turn_q      <= 8'd0;
               end
            end
            S_MOVE: if (go) begin
               pmove_q <= player_move;
               amove_q <= ai_move;
            end
            S_P_CALC:  dmg_q <= calc_dmg(pmove_q, player_atk);
            S_P_APPLY: begin
               if (pmove_q == MV_HEAL) player_hp_q <= heal(player_hp_q);
               else                    ai_hp_q     <= hit(ai_hp_q, dmg_q);
            end
            S_A_CALC:  dmg_q <= calc_dmg(amove_q, ai_atk);
            S_A_APPLY: begin
               if (amove_q == MV_HEAL) ai_hp_q     <= heal(ai_hp_q);
               else                    player_hp_q <= hit(player_hp_q, dmg_q);
            end
            S_A_CHECK: if (player_hp_q != 8'd0 && turn_q != 8'd255) turn_q <= turn_q + 8'd1;
            // A press in an end state routes the shared wait state back to idle, not to a move.
            S_WIN, S_LOSE: if (go) end_q <= 1'b1;
            default: ;
         endcase
      end
   end

   assign player_hp  = player_hp_q;
   assign ai_hp      = ai_hp_q;
   assign turn_count = turn_q;
   assign busy       = busy_q;
   assign victory    = victory_q;
   assign loss       = loss_q;
   assign state      = state_q;

endmodule
